// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with per-frame latched config and drain interrupt.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 8,
  parameter int DIV_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DIV_W-1:0]          baud_div,
  input  logic                      parity_en,
  input  logic                      parity_odd,
  input  logic                      two_stop,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         wr_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic                      busy,
  output logic                      uart_out,
  output logic                      transmission_interrupt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic full_q, full_d, empty_q, empty_d, ovf_q, ovf_d, irq_q, irq_d, out_q, out_d;
  logic [2:0] state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, div_new;
  logic [DATA_W-1:0] sh_q, sh_d, head;
  logic [3:0] bit_q, bit_d;
  logic par_en_q, par_en_d, par_bit_q, par_bit_d, stop2_q, stop2_d;
  logic push, pop, tick;
  assign head = mem[rd_ptr_q];
  assign div_new = (baud_div == '0) ? DIV_W'(1) : baud_div;
  assign push = wr_en & ~full_q;
  assign tick = cnt_q == '0;
  assign pop = ~empty_q & ((state_q == IDLE) | ((state_q == STOP) & tick & ~stop2_q));
  assign full = full_q;
  assign empty = empty_q;
  assign level = level_q;
  assign overflow = ovf_q;
  assign busy = state_q != IDLE;
  assign uart_out = out_q;
  assign transmission_interrupt = irq_q;
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
    full_d = level_d == (AW+1)'(DEPTH);
    empty_d = level_d == '0;
    ovf_d = wr_en & full_q;
    state_d = state_q;
    cnt_d = cnt_q;
    div_d = div_q;
    sh_d = sh_q;
    bit_d = bit_q;
    par_en_d = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d = stop2_q;
    out_d = out_q;
    irq_d = 1'b0;
    if (pop) begin
      state_d = START;
      div_d = div_new;
      cnt_d = div_new - 1'b1;
      sh_d = head;
      bit_d = '0;
      par_en_d = parity_en;
      par_bit_d = ^head ^ parity_odd;
      stop2_d = two_stop;
      out_d = 1'b0;
    end else if (state_q != IDLE && !tick) begin
      cnt_d = cnt_q - 1'b1;
    end else if (state_q != IDLE) begin
      cnt_d = div_q - 1'b1;
      case (state_q)
        START: begin
          state_d = DATA;
          out_d = sh_q[0];
        end
        DATA: if (bit_q == 4'(DATA_W-1)) begin
          state_d = par_en_q ? PARITY : STOP;
          out_d = par_en_q ? par_bit_q : 1'b1;
        end else begin
          bit_d = bit_q + 1'b1;
          sh_d = sh_q >> 1;
          out_d = sh_q[1];
        end
        PARITY: begin
          state_d = STOP;
          out_d = 1'b1;
        end
        default: if (stop2_q) stop2_d = 1'b0;
        else begin
          state_d = IDLE;
          irq_d = 1'b1;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset && push) mem[wr_ptr_q] <= wr_data;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
      ovf_q <= 1'b0;
      irq_q <= 1'b0;
      out_q <= 1'b1;
      state_q <= IDLE;
      cnt_q <= '0;
      div_q <= DIV_W'(1);
      sh_q <= '0;
      bit_q <= '0;
      par_en_q <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
      full_q <= full_d;
      empty_q <= empty_d;
      ovf_q <= ovf_d;
      irq_q <= irq_d;
      out_q <= out_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      sh_q <= sh_d;
      bit_q <= bit_d;
      par_en_q <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q <= stop2_d;
    end
  end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame (legal 5..8).
REQ-002 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter DIV_W, default 16, width of baud divisor.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port baud_div  input  DIV_W  clock cycles per bit-time; 0 treated as 1.
REQ-007 SHALL have port parity_en  input  1  1 = append parity bit.
REQ-008 SHALL have port parity_odd  input  1  1 = odd parity, 0 = even.
REQ-009 SHALL have port two_stop  input  1  1 = two stop bits.
REQ-010 SHALL have port wr_en  input  1  push request.
REQ-011 SHALL have port wr_data  input  DATA_W  byte to push.
REQ-012 SHALL have port full, empty  output  1 each  FIFO status, registered.
REQ-013 SHALL have port level  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-014 SHALL have port overflow  output  1  one-cycle pulse on dropped write.
REQ-015 SHALL have port busy  output  1  high when FSM not IDLE.
REQ-016 SHALL have port uart_out  output  1  serial line, idle high.
REQ-017 SHALL have port transmission_interrupt  output  1  one-cycle pulse, queue drained.

Function
REQ-018 Push SHALL occur when wr_en=1 and full=0; wr_en=1 with full=1 SHALL drop data and pulse overflow next cycle, even if a pop occurs in that cycle.
REQ-019 Simultaneous push and pop (not full) SHALL leave level unchanged; FIFO order SHALL be strict first-in first-out, pointers wrapping modulo DEPTH.
REQ-020 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-021 IDLE: when empty=0, pop head, latch data, baud_div (0->1), parity_en, parity_odd, two_stop; go START next cycle.
REQ-022 Config inputs SHALL only affect a frame at its pop; changes mid-frame SHALL be ignored.
REQ-023 Each bit SHALL last exactly latched baud_div cycles, counted by an internal down-counter.
REQ-024 START drives 0; DATA drives DATA_W bits LSB first; PARITY (only if parity_en) drives XOR of data bits, inverted when parity_odd; STOP drives 1 for 1 or 2 bit-times.
REQ-025 Latency: wr_en at cycle N into empty FIFO with IDLE FSM SHALL give empty=0 at N+1, pop at N+1, uart_out=0 from N+2.
REQ-026 On the last cycle of STOP with empty=0, the FSM SHALL pop and enter START directly (no idle gap between frames).
REQ-027 On the last cycle of STOP with empty=1, the FSM SHALL return to IDLE and pulse transmission_interrupt for exactly one cycle in the following cycle.
REQ-028 uart_out SHALL be registered and SHALL be 1 in IDLE; busy SHALL equal (state != IDLE).
REQ-029 Frame length SHALL be (1 + DATA_W + parity_en + 1 + two_stop) * baud_div cycles.

Reset
REQ-030 reset=0 at a rising edge SHALL set: uart_out=1, state IDLE, level=0, empty=1, full=0, busy=0, overflow=0, transmission_interrupt=0, pointers 0.
REQ-031 Reset mid-frame SHALL abort the frame, discard FIFO contents, and drive uart_out=1 from the next cycle; no interrupt pulse.
REQ-032 wr_en during reset SHALL be ignored.

Verification
REQ-033 baud_div=4, no parity, 1 stop, write 0x55 -> uart_out 0 for 4 cycles from N+2, then 1,0,1,0,1,0,1,0 each 4 cycles, stop 4 cycles (40-cycle frame), interrupt pulse next cycle.
REQ-034 baud_div=2, parity_en=1, write 0x03 with parity_odd=1 -> parity bit 1; repeat parity_odd=0 -> parity bit 0; frame 22 cycles.
REQ-035 DEPTH=8, baud_div=100, 10 writes on consecutive cycles -> 9 accepted (1 transmitting + 8 queued), full=1, 10th dropped with one overflow pulse, all 9 bytes emitted in order.
REQ-036 Two writes back-to-back, baud_div=3, two_stop=1 -> second start bit immediately follows 6 stop cycles, single interrupt after second frame.
REQ-037 Reset asserted mid-DATA of a frame with 3 bytes queued -> uart_out=1, level=0, empty=1 next cycle; no further output after release.
REQ-038 baud_div=0 -> each bit lasts 1 cycle, 10-cycle frame for DATA_W=8, no parity, 1 stop.
